// File: rtl/packer_pkg.sv
// Shared helpers for the lane-packing blocks: bit counting and counter-width sizing.
// Helpers accept vectors up to MaxW bits wide; wider lanes must widen MaxW.
package packer_pkg;

    localparam int MaxW = 64;

    function automatic int unsigned popcount(input logic [MaxW-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MaxW; i++) begin
            if (v[i]) begin
                n++;
            end
        end
        return n;
    endfunction

    // Bits needed to hold any value in 0..n inclusive.
    function automatic int unsigned bitsFor(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_compactor.sv
// Combinational compaction of the masked bits of one beat into the low end of a word.
// The lowest-index selected bit lands at bit 0 and relative order is preserved.
module bit_compactor
    import packer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]            data_i,
    input  logic [W-1:0]            mask_i,
    output logic [W-1:0]            packed_o,
    output logic [bitsFor(W)-1:0]   popcount_o
);

    localparam int PW = bitsFor(W);

    always_comb begin
        int unsigned pos;
        packed_o = '0;
        pos      = 0;
        for (int i = 0; i < W; i++) begin
            if (mask_i[i]) begin
                packed_o = packed_o | (W'(data_i[i]) << pos);
                pos++;
            end
        end
        popcount_o = PW'(popcount(MaxW'(mask_i)));
    end

endmodule

// File: rtl/bit_packer_flow.sv
// Packs masked input bits into a dense stream of W-bit words with valid/ready on both
// sides and a flush that drains a trailing partial word together with its bit count.
module bit_packer_flow
    import packer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    input  logic [W-1:0]            in_mask,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_data,
    output logic [bitsFor(W)-1:0]   out_count
);

    localparam int CW  = bitsFor(2 * W);
    localparam int OCW = bitsFor(W);

    logic [2*W-1:0] accQ, accD;
    logic [CW-1:0]  countQ, countD;
    logic           flushPendingQ, flushPendingD;

    logic [W-1:0]   packedBits;
    logic [OCW-1:0] beatCount;
    logic [CW-1:0]  emitCount;
    logic [CW-1:0]  shiftedCount;
    logic [2*W-1:0] shiftedAcc;
    logic           fire;
    logic           accept;

    bit_compactor #(.W(W)) uCompactor (
        .data_i     (in_data),
        .mask_i     (in_mask),
        .packed_o   (packedBits),
        .popcount_o (beatCount)
    );

    // Handshakes depend only on registered state, so out_ready never reaches in_ready.
    // Bits of accQ at or above countQ are always zero, which keeps partial words clean.
    assign in_ready  = !flushPendingQ && (countQ <= CW'(W));
    assign out_valid = (countQ >= CW'(W)) || (flushPendingQ && (countQ != '0));
    assign emitCount = (countQ >= CW'(W)) ? CW'(W) : countQ;
    assign out_data  = accQ[W-1:0];
    assign out_count = OCW'(emitCount);

    assign fire   = out_valid && out_ready;
    assign accept = in_valid && in_ready;

    // Emission happens first, then the new beat is appended above what remains.
    always_comb begin
        shiftedAcc   = fire ? (accQ >> emitCount) : accQ;
        shiftedCount = fire ? (countQ - emitCount) : countQ;
        accD         = shiftedAcc;
        countD       = shiftedCount;
        if (accept) begin
            accD   = shiftedAcc | ({{W{1'b0}}, packedBits} << shiftedCount);
            countD = shiftedCount + CW'(beatCount);
        end
        flushPendingD = flush || (flushPendingQ && (countD != '0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            accQ          <= '0;
            countQ        <= '0;
            flushPendingQ <= 1'b0;
        end else begin
            accQ          <= accD;
            countQ        <= countD;
            flushPendingQ <= flushPendingD;
        end
    end

endmodule

// File: tb/tb_bit_packer_flow.sv
// Directed and randomized checks of bit_packer_flow at W=8 against hand-computed words
// and a bit-queue reference model.
module tb_bit_packer_flow;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] in_mask;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [3:0]   out_count;

    int checks;
    int errors;

    bit refQ[$];

    bit_packer_flow #(.W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_out_count: got %0d expected 0", out_count);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'b1010_1100;
        in_mask   = 8'b1001_1010;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_count !== 4'd4 || out_data !== 8'h0A) begin
            errors++;
            $display("[TB] FAIL basic_first_beat: got v=%b cnt=%0d data=%h expected v=0 cnt=4 data=0a",
                     out_valid, out_count, out_data);
        end
        in_data = 8'b1100_1110;
        in_mask = 8'b0100_1111;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'b1110_1010 || out_count !== 4'd8) begin
            errors++;
            $display("[TB] FAIL basic_word: got v=%b data=%b cnt=%0d expected v=1 data=11101010 cnt=8",
                     out_valid, out_data, out_count);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_in_ready_count9: got %b expected 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_count !== 4'd1 || out_data !== 8'h01 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_residual: got v=%b cnt=%0d data=%h rdy=%b expected v=0 cnt=1 data=01 rdy=1",
                     out_valid, out_count, out_data, in_ready);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || out_count !== 4'd1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_word: got v=%b data=%h cnt=%0d rdy=%b expected v=1 data=01 cnt=1 rdy=0",
                     out_valid, out_data, out_count, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL flush_done: got v=%b rdy=%b cnt=%0d expected v=0 rdy=1 cnt=0",
                     out_valid, in_ready, out_count);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mask   = 8'hFF;
        in_data   = 8'h11;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_first: got v=%b data=%h rdy=%b expected v=1 data=11 rdy=1",
                     out_valid, out_data, in_ready);
        end
        in_data = 8'h22;
        tick();
        in_data = 8'h33;
        checks++;
        if (in_ready !== 1'b0 || out_data !== 8'h11 || out_count !== 4'd8) begin
            errors++;
            $display("[TB] FAIL bp_full: got rdy=%b data=%h cnt=%0d expected rdy=0 data=11 cnt=8",
                     in_ready, out_data, out_count);
        end
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_data !== 8'h11 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_stall: got rdy=%b data=%h v=%b expected rdy=0 data=11 v=1",
                     in_ready, out_data, out_valid);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_data !== 8'h22 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_second: got data=%h v=%b rdy=%b expected data=22 v=1 rdy=1",
                     out_data, out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_data !== 8'h33 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_third: got data=%h v=%b expected data=33 v=1", out_data, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL bp_drained: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, out_count);
        end
    endtask

    task automatic test_zero_mask();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h05;
        in_mask   = 8'h07;
        tick();
        in_data = 8'hFF;
        in_mask = 8'h00;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_count !== 4'd3 || in_ready !== 1'b1 || out_data !== 8'h05) begin
                errors++;
                $display("[TB] FAIL zero_mask_cycle%0d: got v=%b cnt=%0d rdy=%b data=%h expected v=0 cnt=3 rdy=1 data=05",
                         c, out_valid, out_count, in_ready, out_data);
            end
        end
        in_data = 8'h02;
        in_mask = 8'h03;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_count !== 4'd5 || out_data !== 8'h15 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_mask_append: got cnt=%0d data=%h v=%b expected cnt=5 data=15 v=0",
                     out_count, out_data, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_count !== 4'd0 || out_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_mid: got v=%b cnt=%0d data=%h expected v=0 cnt=0 data=00",
                     out_valid, out_count, out_data);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_flush_pending: got v=%b rdy=%b expected v=0 rdy=0", out_valid, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL empty_flush_clear: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] expWord;
        int           take;
        bit           expReady;
        bit           expValid;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            in_mask   = W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            expReady  = (refQ.size() <= W);
            expValid  = (refQ.size() >= W);
            checks++;
            if (in_ready !== expReady || out_valid !== expValid) begin
                errors++;
                $display("[TB] FAIL rand_handshake_c%0d: got rdy=%b v=%b expected rdy=%b v=%b",
                         c, in_ready, out_valid, expReady, expValid);
            end
            if (expValid && out_ready) begin
                for (int i = 0; i < W; i++) expWord[i] = refQ[i];
                checks++;
                if (out_data !== expWord || out_count !== 4'd8) begin
                    errors++;
                    $display("[TB] FAIL rand_word_c%0d: got data=%h cnt=%0d expected data=%h cnt=8",
                             c, out_data, out_count, expWord);
                end
                for (int i = 0; i < W; i++) void'(refQ.pop_front());
            end
            if (in_valid && expReady) begin
                for (int i = 0; i < W; i++) begin
                    if (in_mask[i]) refQ.push_back(in_data[i]);
                end
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        if (refQ.size() >= W) begin
            for (int i = 0; i < W; i++) expWord[i] = refQ[i];
            checks++;
            if (out_data !== expWord || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rand_pre_flush_word: got data=%h v=%b expected data=%h v=1",
                         out_data, out_valid, expWord);
            end
            for (int i = 0; i < W; i++) void'(refQ.pop_front());
        end
        tick();
        flush = 1'b0;
        for (int c = 0; c < 20 && refQ.size() > 0; c++) begin
            take = (refQ.size() >= W) ? W : refQ.size();
            for (int i = 0; i < W; i++) expWord[i] = (i < take) ? refQ[i] : 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== expWord || out_count !== 4'(take)) begin
                errors++;
                $display("[TB] FAIL rand_drain_c%0d: got v=%b data=%h cnt=%0d expected v=1 data=%h cnt=%0d",
                         c, out_valid, out_data, out_count, expWord, take);
            end
            for (int i = 0; i < take; i++) void'(refQ.pop_front());
            tick();
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || refQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_final: got v=%b rdy=%b leftover=%0d expected v=0 rdy=1 leftover=0",
                     out_valid, in_ready, refQ.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_flush();
        test_backpressure();
        test_zero_mask();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
